// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and instruction/NOP constants used by the stage registers.
package hazard_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam int KILL_CYCLES_MAX = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    KILL     = 2'd2,
    ERR      = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: EX holds a load whose destination is read by ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  // x0 is never a real dependency
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, load-use bubbles, redirect kills,
// dmem timeout. Optional perf counters under `HAZARD_PERF_CNT_EN.
//
// state    | meaning
// RUN      | normal flow, load-use and redirect handled in-cycle
// MEM_WAIT | dmem access outstanding, all stages frozen
// KILL     | flushing remaining wrong-path front-end slots
// ERR      | dmem timed out, pipeline frozen until reset
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int KILL_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              hold_pc,
  output logic              hold_if_id,
  output logic              hold_id_ex,
  output logic              hold_ex_mem,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              pc_sel_redirect,
  output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int KW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [KW-1:0] KILL_LOAD = KW'(KILL_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

  hz_state_e     state;
  logic [KW-1:0] kill_cnt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_inc;
  logic          load_use;
  logic          mem_stall;
  logic          in_kill;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req && !dmem_ready;
  // a stall that interrupted KILL keeps its remaining count and resumes it afterwards
  assign in_kill   = (state == KILL) || ((state == MEM_WAIT) && (kill_cnt != '0));
  assign wait_inc  = (state == MEM_WAIT) ? wait_cnt + 1'b1 : WW'(1);
  assign mem_err   = (state == ERR);

  always_comb begin
    hold_pc         = 1'b0;
    hold_if_id      = 1'b0;
    hold_id_ex      = 1'b0;
    hold_ex_mem     = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    pc_sel_redirect = 1'b0;
    if ((state == ERR) || mem_stall) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      hold_id_ex  = 1'b1;
      hold_ex_mem = 1'b1;
    end else if (ex_redirect) begin
      pc_sel_redirect = 1'b1;
      flush_if_id     = 1'b1;
      flush_id_ex     = 1'b1;
    end else if (in_kill) begin
      flush_if_id = 1'b1;
    end else if (load_use) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      kill_cnt <= '0;
      wait_cnt <= '0;
    end else if (state != ERR) begin
      if (mem_stall) begin
        wait_cnt <= wait_inc;
        state    <= (wait_inc >= WAIT_MAX) ? ERR : MEM_WAIT;
      end else begin
        wait_cnt <= '0;
        if (ex_redirect) begin
          kill_cnt <= KILL_LOAD;
          state    <= (KILL_LOAD != '0) ? KILL : RUN;
        end else if (in_kill) begin
          kill_cnt <= kill_cnt - 1'b1;
          state    <= (kill_cnt == KW'(1)) ? RUN : KILL;
        end else begin
          state <= RUN;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hold_pc || hold_if_id || hold_id_ex || hold_ex_mem) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_id_ex && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (KILL_CYCLES=3, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic       flush_if_id, flush_id_ex, pc_sel_redirect, mem_err;
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  // {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, pc_sel}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b1100010;
  localparam logic [6:0] STALL = 7'b1111000;
  localparam logic [6:0] RED   = 7'b0000111;
  localparam logic [6:0] KILLF = 7'b0000100;

  hazard_ctrl #(.REG_AW(5), .KILL_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_redirect     (ex_redirect),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .hold_pc         (hold_pc),
    .hold_if_id      (hold_if_id),
    .hold_id_ex      (hold_id_ex),
    .hold_ex_mem     (hold_ex_mem),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .pc_sel_redirect (pc_sel_redirect),
    .mem_err         (mem_err)
  );

  assign outs = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                 flush_if_id, flush_id_ex, pc_sel_redirect};

  always #5 clk = ~clk;

  task automatic quiet();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b0;
    #3;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, NONE); end
    total++;
    if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [6:0] exp [6];
    exp = '{LU, NONE, LU, NONE, NONE, NONE};
    for (int i = 0; i < 6; i++) begin
      quiet();
      case (i)
        0: begin ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1; end
        1: begin id_rs1 = 5'd5; id_rs1_used = 1; end  // load moved on, bubble in EX
        2: begin ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs1_used = 1;
                 id_rs2 = 5'd7; id_rs2_used = 1; end
        3: begin ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 0; end
        4: begin ex_mem_read = 0; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1; end
        5: begin ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
                 id_rs2 = 5'd0; id_rs2_used = 1; end
        default: ;
      endcase
      #3;
      total++;
      if (outs !== exp[i]) begin bad++; $display("FAIL load_use[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_kill();
    logic [6:0] exp [4];
    exp = '{RED, KILLF, KILLF, NONE};
    for (int i = 0; i < 4; i++) begin
      quiet();
      if (i == 0) begin
        ex_redirect = 1; ex_mem_read = 1; ex_rd = 5'd4; id_rs1 = 5'd4; id_rs1_used = 1;
      end
      #3;
      total++;
      if (outs !== exp[i]) begin bad++; $display("FAIL kill[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_kill_restart();
    logic [6:0] exp [6];
    exp = '{RED, KILLF, RED, KILLF, KILLF, NONE};
    for (int i = 0; i < 6; i++) begin
      quiet();
      ex_redirect = (i == 0 || i == 2);
      #3;
      total++;
      if (outs !== exp[i]) begin bad++; $display("FAIL kill_restart[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    logic [6:0] exp [5];
    exp = '{STALL, STALL, STALL, NONE, NONE};
    for (int i = 0; i < 5; i++) begin
      quiet();
      dmem_req   = (i < 4);
      dmem_ready = (i == 3);
      #3;
      total++;
      if (outs !== exp[i]) begin bad++; $display("FAIL mem_wait[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
    total++;
    if (mem_err !== 1'b0) begin bad++; $display("FAIL mem_wait_err: got %b want 0", mem_err); end
  endtask

  task automatic test_stall_redirect();
    logic [6:0] exp [6];
    exp = '{STALL, STALL, RED, KILLF, KILLF, NONE};
    for (int i = 0; i < 6; i++) begin
      quiet();
      dmem_req    = (i < 3);
      dmem_ready  = (i == 2);
      ex_redirect = (i < 3);
      #3;
      total++;
      if (outs !== exp[i]) begin bad++; $display("FAIL stall_redirect[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_op();
    quiet();
    ex_redirect = 1;
    next_cycle();
    quiet();
    rst = 1'b0;
    #2;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL rst_mid_kill: got %b want %b", outs, NONE); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    #2;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL rst_mid_kill_after: got %b want %b", outs, NONE); end
    dmem_req = 1;
    next_cycle();
    dmem_req = 0;
    rst = 1'b0;
    #2;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL rst_mid_wait: got %b want %b", outs, NONE); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    #2;
    total++;
    if (outs !== NONE) begin bad++; $display("FAIL rst_mid_wait_after: got %b want %b", outs, NONE); end
    next_cycle();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      quiet();
      dmem_req = 1;
      #3;
      total++;
      if ({outs, mem_err} !== {STALL, 1'b0})
        begin bad++; $display("FAIL timeout_wait[%0d]: got %b/%b want %b/0", i, outs, mem_err, STALL); end
      next_cycle();
    end
    #2;
    total++;
    if ({outs, mem_err} !== {STALL, 1'b1})
      begin bad++; $display("FAIL timeout_err: got %b/%b want %b/1", outs, mem_err, STALL); end
    quiet();
    ex_redirect = 1;
    next_cycle();
    next_cycle();
    total++;
    if ({outs, mem_err} !== {STALL, 1'b1})
      begin bad++; $display("FAIL err_sticky: got %b/%b want %b/1", outs, mem_err, STALL); end
    quiet();
    rst = 1'b0;
    #2;
    total++;
    if ({outs, mem_err} !== {NONE, 1'b0})
      begin bad++; $display("FAIL err_reset: got %b/%b want %b/0", outs, mem_err, NONE); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    #3;
    total++;
    if ({outs, mem_err} !== {LU, 1'b0})
      begin bad++; $display("FAIL post_err_load_use: got %b/%b want %b/0", outs, mem_err, LU); end
    next_cycle();
    quiet();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_kill();
    test_kill_restart();
    test_mem_wait();
    test_stall_redirect();
    test_reset_mid_op();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter KILL_CYCLES, default 1 (range 1..4), front-end slots flushed per redirect.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, maximum dmem wait cycles before error.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports id_rs1 / id_rs2, input, REG_AW each, ID-stage source indices; id_rs1_used / id_rs2_used, input, 1 each, source actually read.
REQ-007 SHALL have ports ex_rd, input, REG_AW, EX destination; ex_mem_read, input, 1, EX instruction is a load.
REQ-008 SHALL have ports ex_redirect, input, 1, EX resolved taken branch/jump.
REQ-009 SHALL have ports dmem_req and dmem_ready, input, 1 each, MEM-stage access pending / completing.
REQ-010 SHALL have outputs hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, 1 each, freeze the stage register (driven into each pipeline register's hold input).
REQ-011 SHALL have outputs flush_if_id, flush_id_ex, 1 each, load NOP into the stage register on the next edge; pc_sel_redirect, 1, select EX target into PC.
REQ-012 SHALL have output mem_err, 1, sticky dmem-timeout flag.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, KILL, ERR.
REQ-014 SHALL compute all outputs combinationally from state and inputs; no latency beyond that.
REQ-015 SHALL treat as load-use hazard: ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-016 In RUN with load-use hazard and no higher priority event: assert hold_pc, hold_if_id, flush_id_ex for that cycle only; state stays RUN.
REQ-017 Memory stall (dmem_req && !dmem_ready) SHALL have highest priority: assert all four holds, no flushes, no pc_sel_redirect; enter/stay MEM_WAIT.
REQ-018 MEM_WAIT SHALL count wait cycles; on dmem_ready return to RUN and clear count; when count reaches MEM_TIMEOUT go to ERR and set mem_err.
REQ-019 ex_redirect in RUN with no memory stall SHALL assert pc_sel_redirect, flush_if_id, flush_id_ex in that cycle, overriding load-use; if KILL_CYCLES>1 go to KILL.
REQ-020 KILL SHALL assert flush_if_id for KILL_CYCLES-1 further cycles, then return to RUN; a new ex_redirect in KILL restarts the kill count and reasserts pc_sel_redirect.
REQ-021 ex_redirect during MEM_WAIT SHALL be ignored while stalled (EX is held, signal stays stable) and acted on in the first RUN cycle.
REQ-022 ERR SHALL hold all four stages permanently until reset; mem_err stays 1.
REQ-023 Kill and wait counters SHALL be sized to their parameter and never wrap.

Reset
REQ-024 On rst low, asynchronously: state RUN, counters 0, mem_err 0; all holds, flushes, pc_sel_redirect 0 while input-quiet.
REQ-025 Reset asserted mid-MEM_WAIT or mid-KILL SHALL abandon the operation with no residual flush.

Configuration
REQ-026 Macro HAZARD_PERF_CNT_EN, when defined, SHALL add 32-bit outputs stall_cnt (cycles with any hold) and flush_cnt (cycles with flush_id_ex), saturating at all-ones, reset to 0.
REQ-027 Without HAZARD_PERF_CNT_EN those ports and counters SHALL not exist; other behaviour is identical.

Structure
REQ-028 FSM state encoding and NOP-related constants SHALL live in the shared defines include alongside ADDR_LEN/INST_LEN/NOP_INST.
REQ-029 Load-use comparison SHALL be one combinational sub-module, hazard_detect; everything else in hazard_ctrl.

Verification
REQ-030 Load x5 in EX, ID uses rs1=x5 -> one cycle of hold_pc=hold_if_id=flush_id_ex=1, then normal flow.
REQ-031 Load x0 in EX, ID reads x0 -> no stall.
REQ-032 dmem_req with ready after 3 cycles -> all holds high exactly 3 cycles, state back to RUN.
REQ-033 KILL_CYCLES=3, ex_redirect one cycle -> pc_sel_redirect 1 cycle, flush_if_id 3 consecutive cycles.
REQ-034 MEM_TIMEOUT=4, dmem_ready never -> mem_err rises after 4 wait cycles, holds stay high; rst low clears all.
REQ-035 ex_redirect and memory stall together -> stall only; redirect outputs appear in first cycle after dmem_ready.
